// File: rtl/adc_quantizer.sv
// ADC front-end quantizer.
// Captures a fixed-point sample and its timestamp on each accepted strobe,
// removes a DC offset, rounds half-up to the output format with saturation,
// and keeps emitted/clipped sample counters for host readout.
module adc_quantizer #(
    parameter int in_bits   = 24,
    parameter int in_point  = 16,
    parameter int out_bits  = 8,
    parameter int out_point = 4,
    parameter int decim     = 1,
    parameter int cnt_bits  = 16,
    parameter int time_bits = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic signed [in_bits-1:0]   sig_in,
    input  logic [time_bits-1:0]        time_curr,
    input  logic signed [in_bits-1:0]   offset,
    input  logic                        clear,
    output logic signed [out_bits-1:0]  sig_out,
    output logic [time_bits-1:0]        time_out,
    output logic                        valid_out,
    output logic                        sat_flag,
    output logic [cnt_bits-1:0]         sat_count,
    output logic [cnt_bits-1:0]         samp_count
);

    // Fractional bits dropped by the quantizer.
    localparam int SH   = in_point - out_point;
    // Offset-removed width: one extra bit so the subtraction cannot overflow.
    localparam int D_W  = in_bits + 1;
    // Rounding width: one more bit so adding the half-LSB cannot overflow.
    localparam int R_W  = in_bits + 2;
    localparam int PH_W = (decim > 1) ? $clog2(decim) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(decim - 1);

    // Output range limits, sign-extended to the rounding width.
    localparam logic signed [R_W-1:0] QMAX = {{(R_W-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
    localparam logic signed [R_W-1:0] QMIN = {{(R_W-out_bits+1){1'b1}}, {(out_bits-1){1'b0}}};

    // Reject parameter sets the datapath cannot represent.
    generate
        if (SH < 0) begin : g_bad_point
            $error("adc_quantizer: in_point must be >= out_point");
        end
        if (decim < 1) begin : g_bad_decim
            $error("adc_quantizer: decim must be >= 1");
        end
        if (out_bits > in_bits + 1) begin : g_bad_out
            $error("adc_quantizer: out_bits must not exceed in_bits+1");
        end
    endgenerate

    logic [PH_W-1:0]          ph;
    logic                     accept;
    logic signed [D_W-1:0]    d1;
    logic [time_bits-1:0]     t1;
    logic                     v1;
    logic signed [R_W-1:0]    d1x;
    logic signed [R_W-1:0]    r;
    logic                     clip_hi;
    logic                     clip_lo;
    logic                     clipped;
    logic signed [out_bits-1:0] q;

    // Only phase 0 of the decimation cycle lets a strobe through.
    assign accept = en && (ph == '0);

    // Decimation phase advances on every strobe, accepted or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (clear) begin
            ph <= '0;
        end else if (en) begin
            ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
        end
    end

    // Stage 1: capture offset-removed sample and timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
            t1 <= '0;
        end else begin
            v1 <= accept && !clear;
            if (accept && !clear) begin
                d1 <= {sig_in[in_bits-1], sig_in} - {offset[in_bits-1], offset};
                t1 <= time_curr;
            end
        end
    end

    assign d1x = {d1[D_W-1], d1};

    // Round half toward +inf by adding half an output LSB before the
    // arithmetic shift; no shift needed when the binary points coincide.
    generate
        if (SH > 0) begin : g_round
            localparam logic signed [R_W-1:0] HALF = {{(R_W-1){1'b0}}, 1'b1} << (SH - 1);
            assign r = (d1x + HALF) >>> SH;
        end else begin : g_pass
            assign r = d1x;
        end
    endgenerate

    assign clip_hi = (r > QMAX);
    assign clip_lo = (r < QMIN);
    assign clipped = clip_hi || clip_lo;

    // Saturating narrow to the output width.
    always_comb begin
        q = r[out_bits-1:0];
        if (clip_hi) begin
            q = QMAX[out_bits-1:0];
        end else if (clip_lo) begin
            q = QMIN[out_bits-1:0];
        end
    end

    // Stage 2: register quantized result; data holds between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            sig_out   <= '0;
            time_out  <= '0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= v1;
            if (v1) begin
                sig_out  <= q;
                time_out <= t1;
                sat_flag <= clipped;
            end
        end
    end

    // Counters step together with valid_out; clip count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_count <= '0;
            sat_count  <= '0;
        end else if (clear) begin
            samp_count <= '0;
            sat_count  <= '0;
        end else if (v1) begin
            samp_count <= samp_count + cnt_bits'(1);
            if (clipped && (sat_count != '1)) begin
                sat_count <= sat_count + cnt_bits'(1);
            end
        end
    end

endmodule
